// File: rtl/codec_serializer.sv
// I2S transmitter for a mono 16-bit stream: divides clk down to BCLK, frames
// each sample into left and right slots, and buffers one sample ahead.
module codec_serializer #(
    parameter int HALF_BCLK_CLKS = 8,
    parameter int SLOT_BITS      = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] sample,
    input  logic        sample_valid,
    output logic        sink_ready,
    output logic        aud_bclk,
    output logic        aud_daclrck,
    output logic        aud_dacdat,
    output logic        underrun
);

    localparam int DW = (HALF_BCLK_CLKS > 1) ? $clog2(HALF_BCLK_CLKS) : 1;
    localparam int BW = $clog2(2 * SLOT_BITS);

    localparam logic [DW-1:0] DIV_LAST  = DW'(HALF_BCLK_CLKS - 1);
    localparam logic [DW-1:0] DIV_ONE   = DW'(1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(2 * SLOT_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [BW-1:0] SLOT_SIZE = BW'(SLOT_BITS);
    localparam logic [BW-1:0] POS_FIRST = BW'(1);
    localparam logic [BW-1:0] POS_LAST  = BW'(16);

    logic [DW-1:0] div_cnt_reg;
    logic          bclk_reg;
    logic [BW-1:0] bit_cnt_reg;
    logic          lrck_reg;
    logic          dat_reg;
    logic [15:0]   frame_reg;
    logic [15:0]   holding_reg;
    logic          full_reg;
    logic          ready_reg;
    logic          underrun_reg;

    logic          bclk_fall;
    logic          frame_load;
    logic          accept;
    logic [BW-1:0] bit_cnt_next;
    logic [BW-1:0] slot_pos;
    logic [15:0]   frame_next;
    logic [15:0]   frame_rev;
    logic          dat_next;
    logic          full_next;

    // Reverse the word so slot position p (1..16) indexes bit p-1, MSB first.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_rev
            assign frame_rev[gi] = frame_next[15 - gi];
        end
    endgenerate

    always_comb begin
        bclk_fall    = (div_cnt_reg == DIV_LAST) && bclk_reg;
        bit_cnt_next = (bit_cnt_reg == BIT_LAST) ? '0 : bit_cnt_reg + BIT_ONE;
        frame_load   = bclk_fall && (bit_cnt_reg == BIT_LAST);
        accept       = sample_valid && ready_reg;
        frame_next   = (frame_load && full_reg) ? holding_reg : frame_reg;
        slot_pos     = (bit_cnt_next >= SLOT_SIZE) ? bit_cnt_next - SLOT_SIZE : bit_cnt_next;
        // Position 0 is the I2S one-bit delay; tail positions pad with zeros.
        dat_next = 1'b0;
        if (slot_pos >= POS_FIRST && slot_pos <= POS_LAST) begin
            dat_next = frame_rev[4'(slot_pos - POS_FIRST)];
        end
        // A load drains the holding register before any new accept can refill it.
        full_next = full_reg;
        if (frame_load && full_reg) begin
            full_next = 1'b0;
        end else if (accept) begin
            full_next = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_reg  <= '0;
            bclk_reg     <= 1'b0;
            bit_cnt_reg  <= '0;
            lrck_reg     <= 1'b0;
            dat_reg      <= 1'b0;
            frame_reg    <= '0;
            holding_reg  <= '0;
            full_reg     <= 1'b0;
            ready_reg    <= 1'b1;
            underrun_reg <= 1'b0;
        end else begin
            div_cnt_reg <= (div_cnt_reg == DIV_LAST) ? '0 : div_cnt_reg + DIV_ONE;
            if (div_cnt_reg == DIV_LAST) begin
                bclk_reg <= ~bclk_reg;
            end
            if (bclk_fall) begin
                bit_cnt_reg <= bit_cnt_next;
                lrck_reg    <= (bit_cnt_next >= SLOT_SIZE);
                dat_reg     <= dat_next;
                frame_reg   <= frame_next;
            end
            if (accept) begin
                holding_reg <= sample;
            end
            full_reg     <= full_next;
            ready_reg    <= ~full_next;
            underrun_reg <= frame_load && !full_reg;
        end
    end

    assign sink_ready  = ready_reg;
    assign aud_bclk    = bclk_reg;
    assign aud_daclrck = lrck_reg;
    assign aud_dacdat  = dat_reg;
    assign underrun    = underrun_reg;

endmodule

// File: doc/codec_serializer.md
CODEC_SERIALIZER -- requirements
Module: codec_serializer

Interface
REQ-001 SHALL have parameter HALF_BCLK_CLKS, default 8, meaning clk cycles per BCLK half-period (BCLK = 3.125 MHz at 50 MHz clk).
REQ-002 SHALL have parameter SLOT_BITS, default 32, meaning BCLK periods per channel slot (frame = 2*SLOT_BITS; 48.83 kHz at defaults).
REQ-003 SHALL have port clk, input, 1, the single 50 MHz system clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port sample, input, 16, two's-complement mono sample from the upstream tone generator.
REQ-006 SHALL have port sample_valid, input, 1, sample is offered this cycle.
REQ-007 SHALL have port sink_ready, output, 1, holding register empty; a sample is accepted when sample_valid and sink_ready are both 1.
REQ-008 SHALL have port aud_bclk, output, 1, I2S bit clock to the codec.
REQ-009 SHALL have port aud_daclrck, output, 1, I2S word select; 0 = left slot, 1 = right slot.
REQ-010 SHALL have port aud_dacdat, output, 1, I2S serial data, MSB first.
REQ-011 SHALL have port underrun, output, 1, one-cycle pulse when a frame starts with no new sample.

Function
REQ-012 SHALL run divider div_cnt 0..HALF_BCLK_CLKS-1; when div_cnt = HALF_BCLK_CLKS-1, div_cnt wraps to 0 and aud_bclk toggles.
REQ-013 SHALL define a BCLK falling edge as the cycle in which aud_bclk toggles 1->0; bit_cnt (0..2*SLOT_BITS-1) increments and wraps only on that cycle.
REQ-014 SHALL drive aud_daclrck = 1 iff bit_cnt >= SLOT_BITS, registered together with bit_cnt.
REQ-015 SHALL change aud_daclrck and aud_dacdat only on BCLK falling edges; both stable across every BCLK rising edge.
REQ-016 SHALL, with slot position p = bit_cnt mod SLOT_BITS, drive aud_dacdat = frame_sample[16-p] for p = 1..16, and 0 for p = 0 and p = 17..SLOT_BITS-1 (I2S one-bit delay).
REQ-017 SHALL send the same frame_sample in left and right slots (mono duplicated).
REQ-018 SHALL perform a frame load on the falling edge where bit_cnt wraps 2*SLOT_BITS-1 -> 0: if holding full, frame_sample <= holding and holding becomes empty; else frame_sample unchanged and underrun pulses 1 for exactly that cycle.
REQ-019 SHALL set holding full and capture sample on the cycle sample_valid & sink_ready; sink_ready is registered and equals not-full.
REQ-020 SHALL NOT bypass: an accept in the same cycle as a frame load with holding empty still produces underrun; the accepted sample waits for the next frame.
REQ-021 SHALL, on accept and load in the same cycle with holding full, load the old holding value and leave holding empty (sink_ready stays 0 since the incoming handshake cannot occur while full).
REQ-022 SHALL ignore sample while sink_ready = 0; sample_valid may stay high without effect.
REQ-023 SHALL give first-sample latency: an accepted sample appears as aud_dacdat MSB at the BCLK falling edge after the next frame load (p = 1).

Reset
REQ-024 SHALL, while reset = 1 at a clk edge, set div_cnt = 0, bit_cnt = 0, aud_bclk = 0, aud_daclrck = 0, aud_dacdat = 0, frame_sample = 0, holding empty, sink_ready = 1, underrun = 0.
REQ-025 SHALL, on reset mid-frame, abandon the frame and discard the holding sample; first falling edge after release is at clk cycle 2*HALF_BCLK_CLKS.
REQ-026 SHALL treat the first wrap after reset as a normal frame load (underrun if no sample was accepted).

Verification
REQ-027 Reset released, no samples -> aud_bclk period 16 clk, aud_daclrck period 1024 clk, aud_dacdat always 0, underrun pulse every 1024 clk, sink_ready = 1.
REQ-028 Offer sample 16'hA5C3 once -> sink_ready 0 next cycle; after next frame load left and right slots each shift 1010010111000011 at p = 1..16, zeros elsewhere; sink_ready returns 1 on load cycle +1.
REQ-029 sample_valid held high with 16'h7FFF then 16'h8000 -> one sample accepted per frame, no underrun, consecutive frames carry 7FFF then 8000, no sample dropped or duplicated.
REQ-030 Accept timed on exact frame-load cycle with holding empty -> underrun = 1 that cycle, frame repeats previous value, accepted sample appears in following frame.
REQ-031 Assert reset for 3 cycles mid-right-slot with holding full -> all outputs take REQ-024 values, sink_ready = 1, held sample never transmitted.
REQ-032 Sample aud_dacdat/aud_daclrck at every aud_bclk rising edge against a reference I2S decoder model -> decoded left = right = sent samples, zero mismatches over 20 frames.
